// File: rtl/mem_pkg.sv
// Shared opcodes, size/direction/error codes and FSM state encoding for the
// load/store controller.
package mem_pkg;

  localparam logic [3:0] OP_LD = 4'b1001;
  localparam logic [3:0] OP_ST = 4'b1010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2,
    StErr    = 2'd3
  } state_e;

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane steering: store data/byte-enable placement and
// load data extraction with sign or zero extension.
module lane_align
  import mem_pkg::*;
#(
  parameter int unsigned DW = 32,
  localparam int unsigned BW = DW / 8,
  localparam int unsigned LW = $clog2(BW)
) (
  input  logic [1:0]    st_size,
  input  logic [LW-1:0] st_lane,
  input  logic [DW-1:0] st_data,
  output logic [BW-1:0] st_be,
  output logic [DW-1:0] st_wdata,
  input  logic [1:0]    ld_size,
  input  logic [LW-1:0] ld_lane,
  input  logic          ld_uns,
  input  logic [DW-1:0] ld_rdata,
  output logic [DW-1:0] ld_data
);

  logic [BW-1:0] be_base;
  logic [DW-1:0] ld_shift;
  logic [DW-1:0] keep;
  logic          sbit;

  // Store side: place right-aligned data and enables into the addressed lanes.
  always_comb begin
    be_base = BW'(15);
    case (st_size)
      SZ_BYTE: be_base = BW'(1);
      SZ_HALF: be_base = BW'(3);
      default: be_base = BW'(15);
    endcase
    st_be    = be_base << st_lane;
    st_wdata = st_data << {st_lane, 3'b000};
  end

  // Load side: bring the addressed lanes down to bit 0, then fill the upper bits.
  always_comb begin
    ld_shift = ld_rdata >> {ld_lane, 3'b000};
    keep     = DW'(32'hFFFF_FFFF);
    sbit     = ld_shift[31];
    case (ld_size)
      SZ_BYTE: begin
        keep = DW'(8'hFF);
        sbit = ld_shift[7];
      end
      SZ_HALF: begin
        keep = DW'(16'hFFFF);
        sbit = ld_shift[15];
      end
      default: begin
        keep = DW'(32'hFFFF_FFFF);
        sbit = ld_shift[31];
      end
    endcase
    ld_data = (ld_shift & keep) | ((~ld_uns & sbit) ? ~keep : '0);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between execute and data memory: alignment check,
// single outstanding access with timeout, registered result/status pulses.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      op,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [AW-1:0]   s1,
  input  logic [DW-1:0]   s2,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic [1:0]      mem_rw,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0]   ld_data,
  output logic            ld_valid,
  output logic            st_done,
  output logic            busy,
  output logic            err,
  output logic [1:0]      err_cause
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned LW = $clog2(BW);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          is_ld_q, is_ld_d;
  logic [1:0]    pend_q, pend_d;
  logic [1:0]    rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [BW-1:0] be_q, be_d;
  logic [DW-1:0] ld_data_q, ld_data_d;
  logic          ld_valid_q, ld_valid_d;
  logic          st_done_q, st_done_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [1:0]    cause_q, cause_d;

  logic [BW-1:0] al_be;
  logic [DW-1:0] al_wdata;
  logic [DW-1:0] al_ld;
  logic          is_mem_op;
  logic          misalign;

  lane_align #(
    .DW(DW)
  ) u_lane_align (
    .st_size (size),
    .st_lane (s1[LW-1:0]),
    .st_data (s2),
    .st_be   (al_be),
    .st_wdata(al_wdata),
    .ld_size (size_q),
    .ld_lane (lane_q),
    .ld_uns  (uns_q),
    .ld_rdata(mem_rdata),
    .ld_data (al_ld)
  );

  assign is_mem_op = (op == OP_LD) || (op == OP_ST);
  // Reserved size 2'b11 is checked as a word.
  assign misalign  = ((size == SZ_HALF) && s1[0]) || (size[1] && (s1[1:0] != 2'b00));

  // Next-state, datapath capture and registered-output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    size_d    = size_q;
    uns_d     = uns_q;
    is_ld_d   = is_ld_q;
    pend_d    = pend_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    ld_data_d = ld_data_q;
    unique case (state_q)
      StIdle: begin
        // busy_q still covers the pulse cycle, so a held op is not re-accepted.
        if (is_mem_op && !busy_q) begin
          is_ld_d = (op == OP_LD);
          if (misalign) begin
            state_d = StErr;
            pend_d  = ERR_MISALIGN;
          end else begin
            state_d = StAccess;
            cnt_d   = '0;
            lane_d  = s1[LW-1:0];
            size_d  = size;
            uns_d   = uns;
            addr_d  = s1 & ~AW'(BW - 1);
            be_d    = al_be;
            wdata_d = al_wdata;
            rw_d    = (op == OP_LD) ? RW_READ : RW_WRITE;
          end
        end
      end
      StAccess: begin
        if (mem_ready) begin
          state_d = StDone;
          rw_d    = RW_IDLE;
          if (is_ld_q) ld_data_d = al_ld;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = StErr;
          pend_d  = ERR_TIMEOUT;
          rw_d    = RW_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    ld_valid_d = (state_q == StDone) && is_ld_q;
    st_done_d  = (state_q == StDone) && !is_ld_q;
    err_d      = (state_q == StErr);
    cause_d    = (state_q == StErr) ? pend_q : cause_q;
    busy_d     = (state_q != StIdle) || (state_d != StIdle);
  end

  // State and output registers; reset drops the memory request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lane_q     <= '0;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      is_ld_q    <= 1'b0;
      pend_q     <= ERR_NONE;
      rw_q       <= RW_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      st_done_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      cause_q    <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      is_ld_q    <= is_ld_d;
      pend_q     <= pend_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      st_done_q  <= st_done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      cause_q    <= cause_d;
    end
  end

  assign mem_rw    = rw_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign ld_data   = ld_data_q;
  assign ld_valid  = ld_valid_q;
  assign st_done   = st_done_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign err_cause = cause_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random
// loads/stores checked against a cycle-timeline reference model.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  op;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] s1, s2, mem_rdata;
  logic        mem_ready;
  logic [1:0]  mem_rw;
  logic [31:0] mem_addr, mem_wdata, ld_data;
  logic [3:0]  mem_be;
  logic        ld_valid, st_done, busy, err;
  logic [1:0]  err_cause;

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_ld = '0;
  logic [1:0]  last_cause = '0;

  mem_access_ctrl #(
    .DW(32),
    .AW(32),
    .TIMEOUT(T)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .size     (size),
    .uns      (uns),
    .s1       (s1),
    .s2       (s2),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_rw   (mem_rw),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .ld_data  (ld_data),
    .ld_valid (ld_valid),
    .st_done  (st_done),
    .busy     (busy),
    .err      (err),
    .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference load result: gather nb bytes starting at lane, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] rd, input int lane, input int nb,
                                           input logic u);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < nb; b++) v = v | (64'((rd >> (8 * (lane + b))) & 32'hFF) << (8 * b));
    if (!u && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
    return v[31:0];
  endfunction

  // One operation: d = wait cycles before mem_ready (negative: never ready).
  // Starts and ends at a falling edge; op is held until busy is seen low.
  task automatic run_op(input string nm, input logic [3:0] o, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] s,
                        input logic [31:0] rd, input int d, input bit swap);
    int lane, nb, exp_rw_cnt, exp_pulse_i, exp_busy_low, exp_kind;
    bit act, mis, tmo, is_ld;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, bmask, exp_ld;
    int rw_cnt, rw_bad, pulse_i, pulse_kind, npulse, busy_low;
    logic [1:0]  rw_first, cause_at;
    logic [31:0] addr_c, wd_c, ld_at;
    logic [3:0]  be_c;

    lane  = int'(a[1:0]);
    nb    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    act   = (o == OP_LD) || (o == OP_ST);
    is_ld = (o == OP_LD);
    mis   = act && (((nb == 2) && a[0]) || ((nb == 4) && (lane != 0)));
    tmo   = act && !mis && (d < 0);
    exp_rw_cnt   = (!act || mis) ? 0 : tmo ? T : d + 1;
    exp_pulse_i  = mis ? 1 : tmo ? T + 1 : d + 2;
    exp_busy_low = act ? exp_pulse_i + 1 : 0;
    exp_kind     = (mis || tmo) ? 3 : is_ld ? 1 : 2;
    exp_be = 4'(((1 << nb) - 1) << lane);
    exp_wd = '0;
    bmask  = '0;
    for (int b = 0; b < 4; b++) begin
      if (exp_be[b]) begin
        exp_wd = exp_wd | (((s >> (8 * (b - lane))) & 32'hFF) << (8 * b));
        bmask  = bmask | (32'hFF << (8 * b));
      end
    end
    exp_ld = ref_load(rd, lane, nb, u);

    op = o; size = sz; uns = u; s1 = a; s2 = s; mem_rdata = rd;
    mem_ready = (d == 0);
    rw_cnt = 0; rw_bad = 0; pulse_i = -1; pulse_kind = 0; npulse = 0; busy_low = -1;
    rw_first = '0; cause_at = '0; addr_c = '0; wd_c = '0; ld_at = '0; be_c = '0;

    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_rw !== RW_IDLE) begin
        if (rw_cnt == 0) begin
          rw_first = mem_rw; addr_c = mem_addr; be_c = mem_be; wd_c = mem_wdata;
        end else if (mem_rw !== rw_first) begin
          rw_bad++;
        end
        rw_cnt++;
      end
      if (ld_valid || st_done || err) begin
        if (pulse_i < 0) begin
          pulse_i = i;
          pulse_kind = ld_valid ? 1 : st_done ? 2 : 3;
          ld_at = ld_data;
          cause_at = err_cause;
        end
        npulse = npulse + int'(ld_valid) + int'(st_done) + int'(err);
      end
      if (!busy) begin
        busy_low = i;
        op = 4'h0;
        break;
      end
      if (swap && i == 1) begin
        op = OP_ST;
        s1 = a ^ 32'h10;
      end
      mem_ready = (d >= 0) && (i >= d);
    end
    op = 4'h0;

    if (act && !mis && !tmo && is_ld) last_ld = exp_ld;
    if (mis) last_cause = ERR_MISALIGN;
    if (tmo) last_cause = ERR_TIMEOUT;

    chk({nm, ".rw_cycles"}, 64'(rw_cnt), 64'(exp_rw_cnt));
    if (exp_rw_cnt > 0) begin
      chk({nm, ".rw"}, 64'(rw_first), is_ld ? 64'(RW_READ) : 64'(RW_WRITE));
      chk({nm, ".rw_stable"}, 64'(rw_bad), 64'd0);
      chk({nm, ".addr"}, 64'(addr_c), 64'(a & 32'hFFFF_FFFC));
      chk({nm, ".be"}, 64'(be_c), 64'(exp_be));
      if (!is_ld) chk({nm, ".wdata"}, 64'(wd_c & bmask), 64'(exp_wd));
    end
    chk({nm, ".pulses"}, 64'(npulse), act ? 64'd1 : 64'd0);
    if (act) begin
      chk({nm, ".pulse_at"}, 64'(pulse_i), 64'(exp_pulse_i));
      chk({nm, ".pulse_kind"}, 64'(pulse_kind), 64'(exp_kind));
      if (exp_kind == 1) chk({nm, ".ld_data"}, 64'(ld_at), 64'(exp_ld));
      if (exp_kind == 3) chk({nm, ".err_cause"}, 64'(cause_at), 64'(last_cause));
    end
    chk({nm, ".busy_low_at"}, 64'(busy_low), 64'(exp_busy_low));
    chk({nm, ".ld_hold"}, 64'(ld_data), 64'(last_ld));
    chk({nm, ".cause_hold"}, 64'(err_cause), 64'(last_cause));
  endtask

  initial begin
    int r, d;
    logic [3:0] o;
    rst_n = 1'b0; op = 4'h0; size = 2'b00; uns = 1'b0; s1 = '0; s2 = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.mem_rw", 64'(mem_rw), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.pulses", 64'({ld_valid, st_done, err}), 64'd0);
    chk("reset.err_cause", 64'(err_cause), 64'd0);
    chk("reset.ld_data", 64'(ld_data), 64'd0);
    chk("reset.mem_be", 64'(mem_be), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1_lw", OP_LD, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    run_op("t2_lb_s", OP_LD, SZ_BYTE, 1'b0, 32'h103, 32'h0, 32'h8011_2233, 0, 1'b0);
    chk("t2_lb_s.const", 64'(ld_data), 64'hFFFF_FF80);
    run_op("t2_lb_u", OP_LD, SZ_BYTE, 1'b1, 32'h103, 32'h0, 32'h8011_2233, 0, 1'b0);
    chk("t2_lb_u.const", 64'(ld_data), 64'h0000_0080);
    run_op("t3_sh", OP_ST, SZ_HALF, 1'b0, 32'h202, 32'h0000_ABCD, 32'h0, 0, 1'b0);
    run_op("t4_misalign", OP_LD, SZ_WORD, 1'b0, 32'h101, 32'h0, 32'h1234_5678, 0, 1'b0);
    run_op("t5_timeout", OP_LD, SZ_WORD, 1'b0, 32'h104, 32'h0, 32'h1111_2222, -1, 1'b0);
    run_op("nonmem_op", 4'b0011, SZ_WORD, 1'b0, 32'h108, 32'h0, 32'h0, 0, 1'b0);
    run_op("op_while_busy", OP_LD, SZ_WORD, 1'b0, 32'h108, 32'h5555_AAAA, 32'h0BAD_F00D, 5,
           1'b1);
    run_op("ready_at_limit", OP_LD, SZ_HALF, 1'b0, 32'h10E, 32'h0, 32'h8001_7FFF, T - 1,
           1'b0);
    run_op("rsvd_size_misalign", OP_ST, 2'b11, 1'b0, 32'h206, 32'h0, 32'h0, 0, 1'b0);

    // Reset asserted between clock edges while an access is outstanding.
    op = OP_LD; size = SZ_WORD; uns = 1'b0; s1 = 32'h300; mem_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = 4'h0;
    chk("t6.pre_rw", 64'(mem_rw), 64'(RW_READ));
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst_rw", 64'(mem_rw), 64'd0);
    chk("t6.rst_busy", 64'(busy), 64'd0);
    chk("t6.rst_ld_data", 64'(ld_data), 64'd0);
    chk("t6.rst_cause", 64'(err_cause), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_ld = '0;
    last_cause = '0;
    @(negedge clk);
    run_op("t6_recover", OP_ST, SZ_BYTE, 1'b0, 32'h301, 32'h0000_005A, 32'h0, 1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      d = (r < 8) ? r : -1;
      o = ($urandom_range(0, 1) == 0) ? OP_LD : OP_ST;
      run_op($sformatf("rnd%0d", k), o, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom & 32'h0000_FFFF, $urandom, $urandom, d, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
